// File: rtl/aes_key_expand_if.sv
// Key-schedule bus between the AES control slave, the key-expansion engine and
// the CBC datapath. The control side drives key/strobe, the engine returns the schedule.
interface aes_key_expand_if;
    logic [127:0]  key_in;
    logic          key_start;
    logic [1407:0] round_keys;
    logic          rk_valid;
    logic          busy;
    logic [3:0]    key_epoch;

    modport master (
        output key_in, key_start,
        input  round_keys, rk_valid, busy, key_epoch
    );

    modport slave (
        input  key_in, key_start,
        output round_keys, rk_valid, busy, key_epoch
    );
endinterface

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock, all 11 held in registers.
//   state  | meaning
//   IDLE   | schedule complete (or never started); waiting for key_start
//   EXPAND | writing rk[rnd] from rk[rnd-1]; rnd runs 1..10
module aes_key_expand (
    input  logic            aclk,
    input  logic            areset,
    aes_key_expand_if.slave bus
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic {IDLE, EXPAND} state_t;

    state_t        state, state_next;
    logic [127:0]  rk [11];
    logic [3:0]    rnd;
    logic [7:0]    rcon;
    logic          rk_valid;
    logic          busy;
    logic [3:0]    key_epoch;

    logic          load, step, done;
    logic [127:0]  prev_rk, next_rk;
    logic [31:0]   w0, w1, w2, w3, rot, t, n0, n1, n2, n3;
    logic [1407:0] flat_keys;

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A strobe restarts from any state, so it is decoded ahead of the round step.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        done       = 1'b0;
        if (bus.key_start) begin
            load       = 1'b1;
            state_next = EXPAND;
        end else if (state == EXPAND) begin
            step = 1'b1;
            if (rnd == 4'd10) begin
                done       = 1'b1;
                state_next = IDLE;
            end
        end
    end

    always_comb begin
        prev_rk = '0;
        for (int r = 0; r < 10; r++) begin
            if (rnd == 4'(r + 1)) begin
                prev_rk = rk[r];
            end
        end
    end

    assign w0      = prev_rk[127:96];
    assign w1      = prev_rk[95:64];
    assign w2      = prev_rk[63:32];
    assign w3      = prev_rk[31:0];
    assign rot     = {w3[23:0], w3[31:24]};
    assign t       = sub_word(rot) ^ {rcon, 24'h0};
    assign n0      = w0 ^ t;
    assign n1      = w1 ^ n0;
    assign n2      = w2 ^ n1;
    assign n3      = w3 ^ n2;
    assign next_rk = {n0, n1, n2, n3};

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int r = 0; r < 11; r++) begin
                rk[r] <= '0;
            end
            rnd       <= '0;
            rcon      <= '0;
            rk_valid  <= 1'b0;
            busy      <= 1'b0;
            key_epoch <= '0;
        end else if (load) begin
            rk[0]    <= bus.key_in;
            rnd      <= 4'd1;
            rcon     <= 8'h01;
            rk_valid <= 1'b0;
            busy     <= 1'b1;
        end else if (step) begin
            for (int r = 1; r < 11; r++) begin
                if (rnd == 4'(r)) begin
                    rk[r] <= next_rk;
                end
            end
            rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            rnd  <= rnd + 4'd1;
            if (done) begin
                busy      <= 1'b0;
                rk_valid  <= 1'b1;
                key_epoch <= key_epoch + 4'd1;
            end
        end
    end

    always_comb begin
        flat_keys = '0;
        for (int r = 0; r < 11; r++) begin
            flat_keys[128*r +: 128] = rk[r];
        end
    end

    assign bus.round_keys = flat_keys;
    assign bus.rk_valid   = rk_valid;
    assign bus.busy       = busy;
    assign bus.key_epoch  = key_epoch;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand; expected schedules come from an independent
// word-wise FIPS-197 model whose S-box is derived from GF(2^8) inversion.
module tb_aes_key_expand;

    typedef logic [10:0][127:0] sched_t;
    typedef struct packed {
        sched_t     rk;
        logic [3:0] epoch;
    } exp_t;

    localparam logic [127:0] KEY_A1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_RK1    = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_RK10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic aclk;
    logic areset;
    aes_key_expand_if bus ();

    aes_key_expand dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int         tests = 0;
    int         fails = 0;
    exp_t       sb [$];
    logic [3:0] exp_epoch = 4'd0;
    logic [7:0] sbox_ref [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic sched_t model(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        sched_t      s;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_ref[tmp[31:24]], sbox_ref[tmp[23:16]], sbox_ref[tmp[15:8]], sbox_ref[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) s[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return s;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] dut_rk(input int r);
        return bus.round_keys[128*r +: 128];
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        tick();
        tick();
        areset    = 1'b0;
        exp_epoch = 4'd0;
    endtask

    // Strobe for one cycle; returns in cycle T+1. Only completing keys enter the scoreboard.
    task automatic start_key(input logic [127:0] key, input bit completes);
        exp_t e;
        bus.key_in    = key;
        bus.key_start = 1'b1;
        if (completes) begin
            exp_epoch = exp_epoch + 4'd1;
            e.rk      = model(key);
            e.epoch   = exp_epoch;
            sb.push_back(e);
        end
        tick();
        bus.key_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lat_start, output int lat, output int busy_cycles);
        exp_t e;
        bit   overlap = 1'b0;
        lat         = lat_start;
        busy_cycles = 0;
        while (!bus.rk_valid && lat < 40) begin
            if (bus.busy) busy_cycles++;
            tick();
            lat++;
        end
        if (bus.rk_valid && bus.busy) overlap = 1'b1;
        chk({tag, "_overlap"}, 128'(overlap), 128'd0);
        chk({tag, "_timeout"}, 128'(bus.rk_valid), 128'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 128'(sb.size()), 128'd1);
        end else begin
            e = sb.pop_front();
            for (int r = 0; r < 11; r++) chk($sformatf("%s_rk%0d", tag, r), dut_rk(r), e.rk[r]);
            chk({tag, "_epoch"}, 128'(bus.key_epoch), 128'(e.epoch));
        end
    endtask

    initial begin
        int    lat, bc;
        bit    stale, kept;
        sched_t a1;
        logic [127:0] k;

        bus.key_in    = '0;
        bus.key_start = 1'b0;
        areset        = 1'b0;
        build_sbox();
        a1 = model(KEY_A1);
        chk("model_a1_rk10", a1[10], A1_RK10);

        do_reset();
        for (int r = 0; r < 11; r++) chk($sformatf("rst_rk%0d", r), dut_rk(r), '0);
        chk("rst_valid", 128'(bus.rk_valid), 128'd0);
        chk("rst_busy", 128'(bus.busy), 128'd0);
        chk("rst_epoch", 128'(bus.key_epoch), 128'd0);

        // FIPS-197 A.1
        start_key(KEY_A1, 1'b1);
        chk("a1_busy_t1", 128'(bus.busy), 128'd1);
        chk("a1_rk0_t1", dut_rk(0), KEY_A1);
        chk("a1_valid_t1", 128'(bus.rk_valid), 128'd0);
        wait_done("a1", 1, lat, bc);
        chk("a1_latency", 128'(lat), 128'd11);
        chk("a1_rk1_const", dut_rk(1), A1_RK1);
        chk("a1_rk10_const", dut_rk(10), A1_RK10);
        chk("a1_epoch_const", 128'(bus.key_epoch), 128'd1);

        // All-zero key
        start_key('0, 1'b1);
        wait_done("zero", 1, lat, bc);
        chk("zero_busy_cycles", 128'(bc), 128'd10);
        chk("zero_rk1_const", dut_rk(1), ZERO_RK1);
        chk("zero_rk10_const", dut_rk(10), ZERO_RK10);

        // Restart four cycles into an expansion
        start_key('0, 1'b0);
        tick();
        tick();
        tick();
        start_key(KEY_A1, 1'b1);
        wait_done("restart", 1, lat, bc);
        chk("restart_latency", 128'(lat), 128'd11);
        chk("restart_rk10_const", dut_rk(10), A1_RK10);

        // Back-to-back strobes: second key wins
        start_key('0, 1'b0);
        start_key(KEY_A1, 1'b1);
        wait_done("b2b", 1, lat, bc);
        chk("b2b_latency", 128'(lat), 128'd11);

        // Reset during T+5
        start_key(KEY_A1, 1'b0);
        tick();
        tick();
        tick();
        tick();
        areset = 1'b1;
        tick();
        areset    = 1'b0;
        exp_epoch = 4'd0;
        for (int r = 0; r < 11; r++) chk($sformatf("midrst_rk%0d", r), dut_rk(r), '0);
        chk("midrst_valid", 128'(bus.rk_valid), 128'd0);
        chk("midrst_busy", 128'(bus.busy), 128'd0);
        chk("midrst_epoch", 128'(bus.key_epoch), 128'd0);
        stale = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.rk_valid || bus.busy) stale = 1'b1;
            tick();
        end
        chk("midrst_no_stale", 128'(stale), 128'd0);
        start_key(KEY_A1, 1'b1);
        wait_done("post_rst", 1, lat, bc);
        chk("post_rst_latency", 128'(lat), 128'd11);

        // Strobe while valid: old rk10 held until the new one is written
        start_key('0, 1'b1);
        chk("sv_valid_t1", 128'(bus.rk_valid), 128'd0);
        chk("sv_rk0_t1", dut_rk(0), '0);
        kept = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (dut_rk(10) !== A1_RK10) kept = 1'b0;
            if (i < 9) tick();
        end
        chk("sv_rk10_held", 128'(kept), 128'd1);
        wait_done("sv", 10, lat, bc);
        chk("sv_latency", 128'(lat), 128'd11);

        // Epoch wrap over 16 random keys from reset
        do_reset();
        for (int n = 0; n < 16; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            start_key(k, 1'b1);
            wait_done($sformatf("rnd%0d", n), 1, lat, bc);
        end
        chk("wrap_epoch", 128'(bus.key_epoch), 128'd0);
        chk("sb_drained", 128'(sb.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
